// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store memory master.
//   lsu_state_e : controller state encoding (also exported for debug)
//   SZ_*        : access size codes carried on req_size
// ---------------------------------------------------------------------------
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RMW_RD = 3'd2,
      STORE  = 3'd3,
      RESP   = 3'd4
   } lsu_state_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/lsu_mem_master_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_master_if
// Bundles the CPU request/response channel and the word-addressed data
// memory port of the load/store master.
//   master modport : the LSU (drives req_ready, resp_*, mem_* controls)
//   slave modport  : the CPU + memory side (drives req_*, mem_rdata)
//
// Handshake: a request transfers on a rising clk edge where
// req_valid & req_ready are both high. req_ready is high only while the
// LSU is idle. resp_valid is a single-cycle completion pulse; resp_rdata
// and resp_err stay stable until the next request is accepted.
// ---------------------------------------------------------------------------
interface lsu_mem_master_if #(
   parameter int N = 32
);
   logic         req_valid;
   logic         req_ready;
   logic         req_we;
   logic [1:0]   req_size;
   logic         req_unsigned;
   logic [N-1:0] req_addr;
   logic [N-1:0] req_wdata;
   logic         resp_valid;
   logic [N-1:0] resp_rdata;
   logic         resp_err;
   logic         mem_read;
   logic         mem_write;
   logic [N-1:0] mem_addr;
   logic [N-1:0] mem_wdata;
   logic [N-1:0] mem_rdata;

   modport master (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_read, mem_write, mem_addr, mem_wdata
   );

   modport slave (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align (combinational)
// Byte-lane steering shared by the load and read-modify-write paths.
//   size        : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   lane        : byte offset within the word (addr[1:0])
//   is_unsigned : zero-extend loads when 1, sign-extend when 0
//   rdata       : word read from memory
//   wdata_lo    : low half of the store data (right-aligned)
//   load_data   : selected lane, extended to N bits
//   merged      : rdata with wdata_lo inserted into the addressed lane
// Lanes are little-endian: lane k occupies bits 8k+7:8k.
// ---------------------------------------------------------------------------
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [1:0]   size,
   input  logic [1:0]   lane,
   input  logic         is_unsigned,
   input  logic [N-1:0] rdata,
   input  logic [15:0]  wdata_lo,
   output logic [N-1:0] load_data,
   output logic [N-1:0] merged
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel  = rdata[{lane, 3'b000} +: 8];
      // Half-words are aligned, so only lane[1] picks the half.
      half_sel  = rdata[{lane[1], 4'b0000} +: 16];
      load_data = rdata;
      merged    = rdata;
      case (size)
         SZ_BYTE: begin
            load_data = {{(N-8){byte_sel[7] & ~is_unsigned}}, byte_sel};
            merged[{lane, 3'b000} +: 8] = wdata_lo[7:0];
         end
         SZ_HALF: begin
            load_data = {{(N-16){half_sel[15] & ~is_unsigned}}, half_sel};
            merged[{lane[1], 4'b0000} +: 16] = wdata_lo;
         end
         default: begin
            load_data = rdata;
            merged    = rdata;
         end
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// ---------------------------------------------------------------------------
// lsu_mem_master
// Load/store initiator between the execute stage and a word-addressed data
// memory with combinational read and whole-word writes. Byte/half stores
// are done as read-modify-write. Misaligned, reserved-size and
// out-of-range requests complete with resp_err and never touch memory.
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : lsu_mem_master_if.master (request, response, memory port)
//   state_dbg   : current controller state
//   stat_loads, stat_stores, stat_errs (16b, saturating) : present only
//                 when the LSU_STATS_EN macro is defined
//
// Latency from the accept edge to resp_valid: load 2, word store 2,
// sub-word store 3, error 1.
// ---------------------------------------------------------------------------
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int N     = 32,
   parameter int DEPTH = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   lsu_mem_master_if.master  bus,
   output lsu_state_e        state_dbg
`ifdef LSU_STATS_EN
   ,
   output logic [15:0]       stat_loads,
   output logic [15:0]       stat_stores,
   output logic [15:0]       stat_errs
`endif
);

   localparam logic [N-1:0] DEPTH_W = N'(DEPTH);

   lsu_state_e   state, state_nxt;
   logic         accept;
   logic         req_err;
   logic [1:0]   size_q;
   logic         uns_q;
   logic [N-1:0] addr_q;
   logic [N-1:0] wbuf_q;   // latched store data, later the merged word
   logic [N-1:0] rdata_q;
   logic         err_q;
   logic [N-1:0] load_data;
   logic [N-1:0] merged;

   assign accept = bus.req_valid & (state == IDLE);

   always_comb begin
      req_err = 1'b0;
      case (bus.req_size)
         SZ_BYTE: req_err = 1'b0;
         SZ_HALF: req_err = bus.req_addr[0];
         SZ_WORD: req_err = (bus.req_addr[1:0] != 2'b00);
         default: req_err = 1'b1;
      endcase
      if ({2'b00, bus.req_addr[N-1:2]} >= DEPTH_W) req_err = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (accept) begin
               if (req_err)                     state_nxt = RESP;
               else if (!bus.req_we)            state_nxt = LOAD;
               else if (bus.req_size == SZ_WORD) state_nxt = STORE;
               else                             state_nxt = RMW_RD;
            end
         end
         LOAD: begin
            bus.mem_read = 1'b1;
            bus.mem_addr = {2'b00, addr_q[N-1:2]};
            state_nxt    = RESP;
         end
         RMW_RD: begin
            bus.mem_read = 1'b1;
            bus.mem_addr = {2'b00, addr_q[N-1:2]};
            state_nxt    = STORE;
         end
         STORE: begin
            bus.mem_write = 1'b1;
            bus.mem_addr  = {2'b00, addr_q[N-1:2]};
            bus.mem_wdata = wbuf_q;
            state_nxt     = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   lsu_lane_align #(.N(N)) u_align (
      .size        (size_q),
      .lane        (addr_q[1:0]),
      .is_unsigned (uns_q),
      .rdata       (bus.mem_rdata),
      .wdata_lo    (wbuf_q[15:0]),
      .load_data   (load_data),
      .merged      (merged)
   );

   // Response fields are cleared on accept and then hold until the next one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         size_q  <= '0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wbuf_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            wbuf_q  <= bus.req_wdata;
            rdata_q <= '0;
            err_q   <= req_err;
         end
         if (state == LOAD)   rdata_q <= load_data;
         if (state == RMW_RD) wbuf_q  <= merged;
      end
   end

   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign state_dbg      = state;

`ifdef LSU_STATS_EN
   // Direction is only needed to classify the completion for the counters.
   logic we_q;

   always_ff @(posedge clk) begin
      if (!rst_n)      we_q <= 1'b0;
      else if (accept) we_q <= bus.req_we;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_loads  <= '0;
         stat_stores <= '0;
         stat_errs   <= '0;
      end else if (state == RESP) begin
         if (err_q) begin
            if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
         end else if (we_q) begin
            if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
         end else begin
            if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
         end
      end
   end
`endif

endmodule
